// File: rtl/dbg_capture_ctrl.sv
// rtl/dbg_capture_ctrl.sv - trigger-based debug capture buffer with streamed readout
// Stores qualified probe samples in a circular buffer and replays the newest fill entries after the trigger.
module dbg_capture_ctrl #(
   parameter int DW    = 16,
   parameter int DEPTH = 64,
   parameter int POST  = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arm,
   input  logic          abort,
   input  logic [DW-1:0] trig_mask,
   input  logic [DW-1:0] trig_value,
   input  logic          sample_en,
   input  logic [DW-1:0] sample_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          rd_last,
   output logic [1:0]    state,
   output logic          triggered,
   output logic          done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] POST_C  = CW'(POST);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_POST    = 2'd2,
      S_READOUT = 2'd3
   } state_t;

   logic [DW-1:0] mem_q [DEPTH];
   state_t        state_q;
   logic [AW-1:0] wp_q, wp_d;
   logic [CW-1:0] fill_q, fill_d;
   logic [CW-1:0] post_q;
   logic [CW-1:0] load_q;
   logic          rd_valid_q, rd_last_q, trig_q, done_q;
   logic [DW-1:0] rd_data_q;
   logic          hit, wr_en, xfer, load_en;
   logic [AW-1:0] rd_addr;

   always_comb begin
      hit     = (state_q == S_ARMED) && sample_en &&
                ((sample_data & trig_mask) == (trig_value & trig_mask));
      wr_en   = sample_en && !abort && ((state_q == S_ARMED) || (state_q == S_POST));
      wp_d    = wp_q + 1'b1;
      fill_d  = (fill_q == DEPTH_C) ? fill_q : fill_q + 1'b1;
      xfer    = rd_valid_q && rd_ready;
      // Refill the output register whenever it is empty or being drained this cycle.
      load_en = (state_q == S_READOUT) && (load_q != fill_q) && (!rd_valid_q || rd_ready);
      rd_addr = wp_q - fill_q[AW-1:0] + load_q[AW-1:0];
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wp_q] <= sample_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wp_q       <= '0;
         fill_q     <= '0;
         post_q     <= '0;
         load_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
         trig_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q    <= S_IDLE;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            trig_q     <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (arm) begin
                     wp_q    <= '0;
                     fill_q  <= '0;
                     post_q  <= '0;
                     load_q  <= '0;
                     trig_q  <= 1'b0;
                     state_q <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (sample_en) begin
                     wp_q   <= wp_d;
                     fill_q <= fill_d;
                     if (hit) begin
                        trig_q  <= 1'b1;
                        post_q  <= CW'(1);
                        state_q <= (POST == 1) ? S_READOUT : S_POST;
                     end
                  end
               end
               S_POST: begin
                  if (sample_en) begin
                     wp_q   <= wp_d;
                     fill_q <= fill_d;
                     post_q <= post_q + 1'b1;
                     if (post_q + 1'b1 == POST_C) begin
                        state_q <= S_READOUT;
                     end
                  end
               end
               S_READOUT: begin
                  if (load_en) begin
                     rd_data_q  <= mem_q[rd_addr];
                     rd_valid_q <= 1'b1;
                     rd_last_q  <= (load_q + 1'b1 == fill_q);
                     load_q     <= load_q + 1'b1;
                  end else if (xfer) begin
                     rd_valid_q <= 1'b0;
                     rd_last_q  <= 1'b0;
                  end
                  if (xfer && rd_last_q) begin
                     rd_valid_q <= 1'b0;
                     rd_last_q  <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= S_IDLE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign state     = state_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_last   = rd_last_q;
   assign triggered = trig_q;
   assign done      = done_q;

endmodule

// File: tb/tb_dbg_capture_ctrl.sv
// tb/tb_dbg_capture_ctrl.sv - randomized self-checking bench for dbg_capture_ctrl
// The reference model keeps every stored sample in a queue and expects the newest min(n, DEPTH) back.
module tb_dbg_capture_ctrl;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int POST  = 4;

   logic          clk = 1'b0;
   logic          rst, arm, abort, sample_en, rd_ready;
   logic [DW-1:0] trig_mask, trig_value, sample_data;
   logic          rd_valid, rd_last, triggered, done;
   logic [DW-1:0] rd_data;
   logic [1:0]    state;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] hist[$];
   logic [DW-1:0] expq[$];
   int            mstate;
   bit            mtrig;

   dbg_capture_ctrl #(.DW(DW), .DEPTH(DEPTH), .POST(POST)) dut (
      .clk(clk), .rst(rst), .arm(arm), .abort(abort),
      .trig_mask(trig_mask), .trig_value(trig_value),
      .sample_en(sample_en), .sample_data(sample_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .state(state), .triggered(triggered), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      arm = 0; abort = 0; sample_en = 0; rd_ready = 0; sample_data = '0;
   endtask

   task automatic fill_phase(input logic [DW-1:0] mask, input logic [DW-1:0] value,
                             input int en_pct, input bit count_data, input bit hold_arm,
                             output bit ok);
      int            cyc;
      int            pcnt;
      int            start;
      bit            en;
      logic [DW-1:0] dat;
      logic [DW-1:0] cnt;
      hist.delete();
      expq.delete();
      trig_mask = mask; trig_value = value;
      cnt = '0; pcnt = 0; cyc = 0;
      arm = 1;
      step();
      arm = hold_arm;
      mstate = 1; mtrig = 0;
      checks++;
      if (state !== 2'd1 || triggered !== 1'b0) begin
         errors++;
         $display("FAIL arm_entry: state=%0d triggered=%b, want state=1 triggered=0", state, triggered);
      end
      while (mstate != 3 && cyc < 1000) begin
         en  = (int'($urandom_range(99)) < en_pct);
         dat = count_data ? cnt : DW'($urandom);
         sample_en = en; sample_data = dat;
         step();
         if (en) begin
            if (count_data) cnt = cnt + 1'b1;
            hist.push_back(dat);
            if (mstate == 1) begin
               if ((dat & mask) == (value & mask)) begin
                  mtrig = 1; pcnt = 1;
                  mstate = (pcnt == POST) ? 3 : 2;
               end
            end else begin
               pcnt++;
               if (pcnt == POST) mstate = 3;
            end
         end
         checks++;
         if (state !== 2'(mstate) || triggered !== mtrig) begin
            errors++;
            $display("FAIL capture_state: state=%0d triggered=%b, want state=%0d triggered=%b",
                     state, triggered, mstate, mtrig);
         end
         cyc++;
      end
      sample_en = 0; arm = 0;
      ok = (mstate == 3);
      if (!ok) begin
         checks++; errors++;
         $display("FAIL capture_timeout: no trigger/post completion after %0d cycles, want READOUT", cyc);
      end
      start = (hist.size() > DEPTH) ? hist.size() - DEPTH : 0;
      for (int i = start; i < hist.size(); i++) expq.push_back(hist[i]);
   endtask

   task automatic readout_phase(input int rdy_mode, input int stop_after, output int got);
      int            idx;
      int            cyc;
      int            phase;
      bit            fin;
      bit            rdy;
      bit            prev_stall;
      logic [DW-1:0] prev_data;
      idx = 0; cyc = 0; phase = 0; fin = 0; prev_stall = 0; prev_data = '0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL readout_latency: rd_valid=%b in first READOUT cycle, want 0", rd_valid);
      end
      while (!fin && cyc < 500 && !(stop_after >= 0 && idx >= stop_after)) begin
         case (rdy_mode)
            0:       rdy = 1;
            1:       rdy = (phase % 3 == 0);
            default: rdy = 1'($urandom_range(1));
         endcase
         phase++;
         rd_ready    = rdy;
         sample_en   = 1'($urandom_range(1));
         sample_data = DW'($urandom);
         arm         = 1'($urandom_range(1));
         if (prev_stall) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
               errors++;
               $display("FAIL stall_hold: valid=%b data=%h, want valid=1 data=%h", rd_valid, rd_data, prev_data);
            end
         end
         if (rd_valid === 1'b1 && rdy) begin
            checks++;
            if (idx >= expq.size()) begin
               errors++;
               $display("FAIL extra_word: word %0d data=%h, want only %0d words", idx, rd_data, expq.size());
            end else if (rd_data !== expq[idx] || rd_last !== (idx == expq.size() - 1)) begin
               errors++;
               $display("FAIL word: idx=%0d data=%h last=%b, want data=%h last=%b",
                        idx, rd_data, rd_last, expq[idx], (idx == expq.size() - 1));
            end
            idx++;
            if (idx == expq.size()) fin = 1;
         end
         prev_stall = (rd_valid === 1'b1) && !rdy;
         prev_data  = rd_data;
         step();
         cyc++;
      end
      rd_ready = 0; sample_en = 0; arm = 0;
      got = idx;
      if (fin) begin
         checks++;
         if (state !== 2'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: state=%0d done=%b, want state=0 done=1", state, done);
         end
         if (rdy_mode == 0) begin
            checks++;
            if (cyc != expq.size() + 1) begin
               errors++;
               $display("FAIL throughput: readout took %0d cycles, want %0d", cyc, expq.size() + 1);
            end
         end
         step();
         checks++;
         if (done !== 1'b0 || state !== 2'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_once: done=%b state=%0d valid=%b, want 0 0 0", done, state, rd_valid);
         end
      end else if (stop_after < 0) begin
         checks++; errors++;
         $display("FAIL readout_timeout: got %0d words, want %0d", idx, expq.size());
      end
   endtask

   task automatic capture(input logic [DW-1:0] mask, input logic [DW-1:0] value, input int en_pct,
                          input bit count_data, input bit hold_arm, input int rdy_mode);
      bit ok;
      int got;
      fill_phase(mask, value, en_pct, count_data, hold_arm, ok);
      if (ok) begin
         readout_phase(rdy_mode, -1, got);
      end else begin
         abort = 1; step(); abort = 0;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      trig_mask = '0; trig_value = '0;
      rst = 1;
      step(); step();
      checks++;
      if (state !== 2'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || triggered !== 1'b0 ||
          done !== 1'b0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: state=%0d valid=%b last=%b trig=%b done=%b data=%h, want all 0",
                  state, rd_valid, rd_last, triggered, done, rd_data);
      end
      rst = 0;
      step();
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL reset_release: state=%0d, want 0", state);
      end
   endtask

   task automatic test_spec_example();
      capture(16'hFFFF, 16'h0005, 100, 1'b1, 1'b0, 0);
   endtask

   task automatic test_mask_zero();
      bit ok;
      int got;
      fill_phase('0, DW'($urandom), 60, 1'b0, 1'b0, ok);
      if (ok) begin
         readout_phase(0, -1, got);
         checks++;
         if (got != POST) begin
            errors++;
            $display("FAIL mask_zero_count: got %0d words, want %0d", got, POST);
         end
      end
   endtask

   task automatic test_stall();
      capture(16'h0003, 16'h0001, 80, 1'b0, 1'b0, 1);
   endtask

   task automatic test_arm_held();
      capture(16'h0007, 16'h0002, 50, 1'b0, 1'b1, 0);
   endtask

   task automatic test_abort();
      trig_mask = '0;
      arm = 1; step(); arm = 0;
      sample_en = 1; sample_data = DW'($urandom); step();
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("FAIL abort_setup: state=%0d, want 2", state);
      end
      sample_en = 1; abort = 1; arm = 1; step();
      abort = 0; arm = 0; sample_en = 0;
      checks++;
      if (state !== 2'd0 || rd_valid !== 1'b0 || triggered !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_post: state=%0d valid=%b trig=%b done=%b, want 0 0 0 0",
                  state, rd_valid, triggered, done);
      end
      step();
      checks++;
      if (state !== 2'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: state=%0d done=%b, want 0 0", state, done);
      end
      arm = 1; abort = 1; step(); arm = 0; abort = 0;
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL arm_abort_idle: state=%0d, want 0", state);
      end
      arm = 1; step(); arm = 0;
      sample_en = 1; abort = 1; step(); sample_en = 0; abort = 0;
      checks++;
      if (state !== 2'd0 || triggered !== 1'b0) begin
         errors++;
         $display("FAIL abort_over_trigger: state=%0d trig=%b, want 0 0", state, triggered);
      end
      capture(16'h000F, 16'h0009, 90, 1'b0, 1'b0, 2);
   endtask

   task automatic test_random();
      logic [DW-1:0] m;
      for (int it = 0; it < 20; it++) begin
         m = '0;
         for (int k = 0; k < 3; k++) m[$urandom_range(DW - 1)] = 1'b1;
         capture(m, DW'($urandom), 40 + int'($urandom_range(60)), 1'b0,
                 1'($urandom_range(1)), int'($urandom_range(2)));
      end
   endtask

   task automatic test_rst_readout();
      bit ok;
      int got;
      fill_phase(16'h0003, 16'h0002, 90, 1'b0, 1'b0, ok);
      if (ok) begin
         readout_phase(0, 2, got);
         #2;
         rst = 1;
         #1;
         checks++;
         if (state !== 2'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || triggered !== 1'b0 ||
             done !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL rst_async: state=%0d valid=%b last=%b trig=%b done=%b data=%h, want all 0",
                     state, rd_valid, rd_last, triggered, done, rd_data);
         end
         step();
         rst = 0;
         step();
         checks++;
         if (state !== 2'd0 || done !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: state=%0d done=%b valid=%b, want 0 0 0", state, done, rd_valid);
         end
         step();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: done=%b, want 0", done);
         end
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      trig_mask = '0; trig_value = '0;
      test_reset();
      test_spec_example();
      test_mask_zero();
      test_stall();
      test_arm_held();
      test_abort();
      test_random();
      test_rst_readout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
